// File: rtl/modn_arb_pkg.sv
// Shared types for the mod-N counter arbiter: FSM state encoding and direction constants.
package modn_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int WRAPS_W = 4;

    // Index width that stays legal when only one requester exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, searching cyclically; one-hot result.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/modn_count_arbiter.sv
// Shared mod-N up/down counter handed to one requester at a time by round-robin arbitration.
// Define MODN_ARB_ABORT_EN to let an owner end its run early by dropping req_valid.
module modn_count_arbiter
    import modn_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       cfg_n,
    input  logic [NREQ-1:0]         cfg_dir,
    input  logic [NREQ*WRAPS_W-1:0] cfg_wraps,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic [W-1:0]            count,
    output logic                    wrap,
    output logic [NREQ-1:0]         done
);

    localparam int IW = idx_width(NREQ);

    state_t               state_q, state_d;
    logic [NREQ-1:0]      owner_q;
    logic [W-1:0]         n_q;
    logic                 dir_q;
    logic [WRAPS_W-1:0]   wraps_q;
    logic [W-1:0]         count_q;
    logic [IW-1:0]        ptr_q;

    logic [NREQ-1:0]      arb_gnt;
    logic [IW-1:0]        win_idx;
    logic [W-1:0]         win_n;
    logic                 win_dir;
    logic [WRAPS_W-1:0]   win_wraps;
    logic [W-1:0]         last;
    logic                 at_end;
    logic                 wrap_step;
    logic                 start;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_gnt)
    );

    always_comb begin
        win_idx   = '0;
        win_n     = '0;
        win_dir   = DIR_UP;
        win_wraps = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                win_idx   = IW'(i);
                win_n     = cfg_n[i*W +: W];
                win_dir   = cfg_dir[i];
                win_wraps = cfg_wraps[i*WRAPS_W +: WRAPS_W];
            end
        end
    end

    // N == 0 gives last == all-ones, i.e. a full 2^W modulus.
    assign last      = n_q - 1'b1;
    assign at_end    = (dir_q == DIR_UP) ? (count_q == last) : (count_q == '0);
    assign wrap_step = (state_q == ST_RUN) && at_end;
    assign start     = (state_q == ST_IDLE) && (|req_valid);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|req_valid) state_d = ST_LOAD;
            ST_LOAD: state_d = (wraps_q == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (wrap_step && (wraps_q == WRAPS_W'(1))) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef MODN_ARB_ABORT_EN
        if (((state_q == ST_LOAD) || (state_q == ST_RUN)) && !(|(req_valid & owner_q))) begin
            state_d = ST_DONE;
        end
`endif
    end

    // Output logic
    always_comb begin
        busy  = (state_q != ST_IDLE);
        grant = busy ? owner_q : '0;
        done  = (state_q == ST_DONE) ? owner_q : '0;
        wrap  = wrap_step;
        count = count_q;
    end

    // Datapath: cfg is captured once on the grant and never looked at again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= '0;
            n_q     <= '0;
            dir_q   <= DIR_UP;
            wraps_q <= '0;
            count_q <= '0;
            ptr_q   <= '0;
        end else begin
            if (start) begin
                owner_q <= arb_gnt;
                n_q     <= win_n;
                dir_q   <= win_dir;
                wraps_q <= win_wraps;
                ptr_q   <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            end
            if (state_q == ST_LOAD) begin
                count_q <= (dir_q == DIR_UP) ? '0 : last;
            end
            if (state_q == ST_RUN) begin
                if (dir_q == DIR_UP) begin
                    count_q <= at_end ? '0 : count_q + 1'b1;
                end else begin
                    count_q <= at_end ? last : count_q - 1'b1;
                end
                if (at_end) begin
                    wraps_q <= wraps_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/modn_count_arbiter.md
MODN_COUNT_ARBITER -- requirements
Module: modn_count_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing the counter.
REQ-002 SHALL have parameter W, default 4: counter and modulus width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester run request, level-held until done.
REQ-006 SHALL have port cfg_n  input  NREQ*W  per-requester modulus N, packed, requester i at [i*W +: W].
REQ-007 SHALL have port cfg_dir  input  NREQ  per-requester direction, 0 = up, 1 = down.
REQ-008 SHALL have port cfg_wraps  input  NREQ*4  per-requester number of wrap events to run, packed.
REQ-009 SHALL have port grant  output  NREQ  one-hot owner of the counter; zero when idle.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port count  output  W  shared counter value.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse on each wrap step.
REQ-013 SHALL have port done  output  NREQ  one-cycle pulse to the finishing owner.

Function
REQ-014 SHALL implement FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-015 IDLE: any req_valid high SHALL select one winner round-robin, starting at the index after the last granted; first winner after reset is lowest index.
REQ-016 IDLE -> LOAD SHALL latch the winner's N, dir and wraps and assert grant[winner] from LOAD through DONE inclusive.
REQ-017 LOAD SHALL set count to 0 (up) or N-1 (down); cfg inputs SHALL be ignored after latching.
REQ-018 RUN, up: count == N-1 -> 0 with wrap; else count+1.
REQ-019 RUN, down: count == 0 -> N-1 with wrap; else count-1.
REQ-020 Each wrap SHALL decrement remaining wraps; wrap with remaining == 1 SHALL go to DONE; count holds in DONE.
REQ-021 N == 0 SHALL be treated as modulus 2^W; N == 1 SHALL hold count at 0 and wrap every RUN cycle.
REQ-022 wraps == 0 SHALL go LOAD -> DONE directly, no RUN cycles.
REQ-023 DONE SHALL pulse done[owner] for exactly one cycle, then return to IDLE with grant cleared and count held.
REQ-024 New requests SHALL be arbitrated only in IDLE; minimum one IDLE cycle between consecutive grants.
REQ-025 Request-to-grant latency SHALL be one cycle; wrap arithmetic SHALL be modulo 2^W.

Reset
REQ-026 reset_n low SHALL force IDLE, grant = 0, busy = 0, count = 0, wrap = 0, done = 0, round-robin pointer to index 0, at any time including mid-RUN, without a done pulse.

Configuration
REQ-027 With MODN_ARB_ABORT_EN defined: owner deasserting req_valid in LOAD or RUN SHALL go to DONE next cycle and pulse done[owner].
REQ-028 Without MODN_ARB_ABORT_EN: req_valid SHALL be ignored after grant; the run SHALL always complete.

Structure
REQ-029 A shared package modn_arb_pkg SHALL hold the FSM state enum and the direction constants DIR_UP/DIR_DOWN.
REQ-030 Round-robin selection SHALL be a separate sub-module rr_arbiter (request vector, pointer in; one-hot grant out).

Verification
REQ-031 Req 0 only, N=3, up, wraps=1 -> count 0,1,2,0, one wrap pulse, done[0] one cycle, grant high for 5 cycles.
REQ-032 Req 1, N=4, down, wraps=2 -> count 3,2,1,0,3,2,1,0,3, two wrap pulses, done[1].
REQ-033 req_valid=4'b1111 held, wraps=1 each -> grants in order 0,1,2,3,0, each separated by one IDLE cycle.
REQ-034 N=1, wraps=3 -> count stays 0, wrap high three consecutive RUN cycles, then done; N=0, wraps=1 -> full 16-state cycle.
REQ-035 reset_n low mid-RUN -> all outputs zero immediately, no done pulse; next grant goes to lowest requesting index.
REQ-036 Owner drops req_valid mid-RUN -> with MODN_ARB_ABORT_EN, done next cycle; without it, run completes normally.
